// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encodings and widths for the pipeline hazard controller
package hazard_ctrl_pkg;
   localparam int RegAddrSize = 5;
   localparam int CtrlStateW  = 2;
   typedef enum logic [CtrlStateW-1:0] {
      HzRun       = 2'd0,
      HzLoadStall = 2'd1,
      HzMemWait   = 2'd2,
      HzErr       = 2'd3
   } hz_state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use comparator between the IF_DC sources and the DC_ALU load destination
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [RegAddrSize-1:0] rs1_addr,
   input  logic [RegAddrSize-1:0] rs2_addr,
   input  logic                   rs1_used,
   input  logic                   rs2_used,
   input  logic [RegAddrSize-1:0] rd_addr,
   input  logic                   is_load,
   output logic                   hazard
);
   // x0 is never a real dependency, so it cannot create a hazard
   always_comb
      hazard = is_load && rd_addr != '0 &&
               ((rs1_used && rs1_addr == rd_addr) || (rs2_used && rs2_addr == rd_addr));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencer for load-use, branch and memory-wait hazards; HAZARD_PERF_EN adds perf counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int MEM_TIMEOUT      = 255,
   parameter int CNT_W            = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RegAddrSize-1:0] dc_rs1_addr,
   input  logic [RegAddrSize-1:0] dc_rs2_addr,
   input  logic                   dc_rs1_used,
   input  logic                   dc_rs2_used,
   input  logic [RegAddrSize-1:0] alu_rd_addr,
   input  logic                   alu_is_load,
   input  logic                   branch_taken,
   input  logic                   mem_req,
   input  logic                   mem_ready,
   output logic                   pc_stall,
   output logic                   if_dc_stall,
   output logic                   dc_alu_bubble,
   output logic                   if_dc_flush,
   output logic                   dc_alu_flush,
   output logic                   alu_mem_stall,
   output logic                   mem_wb_bubble,
   output logic                   mem_err,
   output logic [CtrlStateW-1:0]  ctrl_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]            perf_stall_cycles,
   output logic [31:0]            perf_flushes
`endif
);
   hz_state_e        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic             err_n, hazard, memwait, frz, ld, fl;

   hazard_detect u_detect (
      .rs1_addr (dc_rs1_addr),
      .rs2_addr (dc_rs2_addr),
      .rs1_used (dc_rs1_used),
      .rs2_used (dc_rs2_used),
      .rd_addr  (alu_rd_addr),
      .is_load  (alu_is_load),
      .hazard   (hazard)
   );

   assign memwait    = mem_req && !mem_ready;
   assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
   assign ctrl_state = state;

   // next state, counter and the three response classes (freeze, load bubble, flush); all quiet while in reset
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = mem_err;
      frz     = 1'b0;
      ld      = 1'b0;
      fl      = 1'b0;
      if (!rst) begin
         case (state)
            HzRun: begin
               if (memwait) begin
                  frz     = 1'b1;
                  cnt_n   = CNT_W'(1);
                  state_n = HzMemWait;
               end else if (branch_taken) begin
                  fl = 1'b1;
               end else if (hazard) begin
                  ld = 1'b1;
                  if (LOAD_USE_BUBBLES > 1) begin
                     cnt_n   = CNT_W'(1);
                     state_n = HzLoadStall;
                  end
               end
            end
            HzLoadStall: begin
               if (memwait) begin
                  frz     = 1'b1;
                  cnt_n   = CNT_W'(1);
                  state_n = HzMemWait;
               end else begin
                  ld = 1'b1;
                  if (cnt == CNT_W'(LOAD_USE_BUBBLES - 1)) begin
                     cnt_n   = '0;
                     state_n = HzRun;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end
            end
            HzMemWait: begin
               frz = 1'b1;
               if (mem_ready) begin
                  cnt_n   = '0;
                  state_n = HzRun;
               end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
                  err_n   = 1'b1;
                  state_n = HzErr;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            HzErr: frz = 1'b1;
         endcase
      end
   end

   assign pc_stall      = frz | ld;
   assign if_dc_stall   = frz | ld;
   assign dc_alu_bubble = ld;
   assign if_dc_flush   = fl;
   assign dc_alu_flush  = fl;
   assign alu_mem_stall = frz;
   assign mem_wb_bubble = frz;

   // state, counter and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HzRun;
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         mem_err <= err_n;
      end
   end

`ifdef HAZARD_PERF_EN
   // saturating counts of stalled and flushed cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
      end else begin
         if (pc_stall && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (if_dc_flush && !(&perf_flushes)) perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl (default and LOAD_USE_BUBBLES=3/MEM_TIMEOUT=4 instances)
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   typedef struct packed {
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       ld, br, mq, mr;
      logic [8:0] exp;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic u1 = 0, u2 = 0, ld = 0, br = 0, mq = 0, mr = 0;
   wire [6:0] oa, ob;
   wire [1:0] sa, sb;
   wire       ea, eb;
   int checks = 0, failures = 0;
   vec_t v[11];

   always #5 clk = ~clk;

   hazard_ctrl u_a (
      .clk(clk), .rst(rst), .dc_rs1_addr(rs1), .dc_rs2_addr(rs2), .dc_rs1_used(u1), .dc_rs2_used(u2),
      .alu_rd_addr(rd), .alu_is_load(ld), .branch_taken(br), .mem_req(mq), .mem_ready(mr),
      .pc_stall(oa[6]), .if_dc_stall(oa[5]), .dc_alu_bubble(oa[4]), .if_dc_flush(oa[3]),
      .dc_alu_flush(oa[2]), .alu_mem_stall(oa[1]), .mem_wb_bubble(oa[0]), .mem_err(ea), .ctrl_state(sa)
`ifdef HAZARD_PERF_EN
      , .perf_stall_cycles(), .perf_flushes()
`endif
   );

   hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst), .dc_rs1_addr(rs1), .dc_rs2_addr(rs2), .dc_rs1_used(u1), .dc_rs2_used(u2),
      .alu_rd_addr(rd), .alu_is_load(ld), .branch_taken(br), .mem_req(mq), .mem_ready(mr),
      .pc_stall(ob[6]), .if_dc_stall(ob[5]), .dc_alu_bubble(ob[4]), .if_dc_flush(ob[3]),
      .dc_alu_flush(ob[2]), .alu_mem_stall(ob[1]), .mem_wb_bubble(ob[0]), .mem_err(eb), .ctrl_state(sb)
`ifdef HAZARD_PERF_EN
      , .perf_stall_cycles(), .perf_flushes()
`endif
   );

   function automatic vec_t mk(input logic [4:0] a1, a2, input logic f1, f2, input logic [4:0] d,
                               input logic l, b, q, r, input logic [8:0] e);
      mk = '{rs1:a1, rs2:a2, u1:f1, u2:f2, rd:d, ld:l, br:b, mq:q, mr:r, exp:e};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; ld = 0; br = 0; mq = 0; mr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic set_hz();
      rs1 = 5'd5; u1 = 1; rd = 5'd5; ld = 1;
   endtask

   initial begin
      // exp = {pc, if_dc_stall, bubble, if_dc_flush, dc_alu_flush, alu_mem_stall, mem_wb_bubble, state[1:0]}
      v[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000);
      v[1]  = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 9'b111000000);
      v[2]  = mk(3, 5, 1, 1, 5, 1, 0, 0, 0, 9'b111000000);
      v[3]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 9'b000000000);
      v[4]  = mk(1, 7, 1, 0, 7, 1, 0, 0, 0, 9'b000000000);
      v[5]  = mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 9'b000000000);
      v[6]  = mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 9'b000110000);
      v[7]  = mk(5, 0, 1, 0, 5, 1, 0, 1, 1, 9'b111000000);
      v[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 9'b000110000);
      v[9]  = mk(9, 9, 0, 1, 9, 1, 0, 0, 0, 9'b111000000);
      v[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000);

      idle();
      #2;
      chk("reset_a", {7'b0, oa, sa, ea}, 16'h0);
      chk("reset_b", {7'b0, ob, sb, eb}, 16'h0);
      do_reset();

      // single-cycle RUN vectors on the one-bubble instance
      for (int i = 0; i < 11; i++) begin
         rs1 = v[i].rs1; rs2 = v[i].rs2; u1 = v[i].u1; u2 = v[i].u2; rd = v[i].rd;
         ld = v[i].ld; br = v[i].br; mq = v[i].mq; mr = v[i].mr;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {7'b0, oa, sa}, {7'b0, v[i].exp});
         step();
      end

      // three-bubble load-use: state 0,1,1 then back to RUN
      do_reset();
      set_hz();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("lu3_c%0d", c), {11'b0, ob[6:4], sb}, {11'b0, 3'b111, (c == 0) ? 2'd0 : 2'd1});
         step();
      end
      idle();
      @(negedge clk);
      chk("lu3_exit", {9'b0, ob, sb}, 16'h0);
      step();

      // memory wait: ready low 4 cycles then high
      do_reset();
      mq = 1;
      for (int c = 0; c < 6; c++) begin
         mr = (c == 4);
         if (c == 5) idle();
         @(negedge clk);
         chk($sformatf("mw_c%0d", c), {11'b0, oa[6], oa[1], oa[0], sa},
             {11'b0, (c < 5) ? 3'b111 : 3'b000, (c == 0 || c == 5) ? 2'd0 : 2'd2});
         step();
      end

      // branch + hazard + memwait together: freeze first, flush after ready
      do_reset();
      set_hz(); br = 1; mq = 1; mr = 0;
      @(negedge clk);
      chk("bmw_c0", {7'b0, oa, sa}, {7'b0, 9'b110001100});
      step();
      mr = 1;
      @(negedge clk);
      chk("bmw_c1", {7'b0, oa, sa}, {7'b0, 9'b110001110});
      step();
      mq = 0; mr = 0;
      @(negedge clk);
      chk("bmw_c2", {7'b0, oa, sa}, {7'b0, 9'b000110000});
      step();

      // timeout of 4 on instance b: ERR with sticky mem_err
      do_reset();
      mq = 1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk($sformatf("to_c%0d", c), {10'b0, ob[6], ob[5], ob[1], sb, eb},
             {10'b0, 3'b111, (c == 0) ? 3'b000 : (c < 5) ? 3'b100 : 3'b111});
         step();
      end

      // async reset mid-wait clears everything before the next edge
      do_reset();
      mq = 1;
      step();
      @(negedge clk);
      chk("ar_wait", {14'b0, sb}, 16'd2);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_b", {7'b0, ob, sb, eb}, 16'h0);
      chk("ar_a", {7'b0, oa, sa, ea}, 16'h0);
      idle();
      step();
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
